// File: rtl/membus_pkg.sv
// Shared constants for the memory bus router: FSM encoding, open-bus value and the
// default PC-style region map (RAM at 0, CGA window at B8000, BIOS at F0000).
package membus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [7:0]  DEF_OPEN_BUS = 8'hFF;

    // Index 0 is the rightmost field.
    localparam logic [59:0] DEF_BASE  = {20'hF0000, 20'hB8000, 20'h00000};
    localparam logic [59:0] DEF_MASK  = {20'hFE000, 20'hFE000, 20'hC0000};
    localparam logic [5:0]  DEF_WAITS = {2'd0, 2'd1, 2'd0};
    localparam logic [2:0]  DEF_RO    = 3'b100;

endpackage

// File: rtl/region_decode.sv
// Combinational address decoder: flags a hit and returns the lowest matching region index.
module region_decode #(
    parameter int ADDR_W = 20,
    parameter int NREG   = 3,
    parameter int IDX_W  = 2,
    parameter logic [NREG*ADDR_W-1:0] BASE = '0,
    parameter logic [NREG*ADDR_W-1:0] MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
                (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/membus_router.sv
// CPU-side memory bus router: decodes an access to one of NREG regions, holds the
// region select for its wait-state count and returns a one-cycle ready pulse.
module membus_router
    import membus_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int NREG   = 3,
    parameter logic [NREG*ADDR_W-1:0] BASE     = DEF_BASE,
    parameter logic [NREG*ADDR_W-1:0] MASK     = DEF_MASK,
    parameter logic [NREG*2-1:0]      WAITS    = DEF_WAITS,
    parameter logic [NREG-1:0]        RO       = DEF_RO,
    parameter logic [DATA_W-1:0]      OPEN_BUS = DEF_OPEN_BUS
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     cpu_req,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_we,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [NREG-1:0]          mem_sel,
    output logic [NREG-1:0]          mem_we,
    input  logic [NREG*DATA_W-1:0]   mem_q,
    output logic [7:0]               err_count
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [1:0]       state;
    logic [1:0]       wait_cnt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_hit;
    logic             lat_we;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [1:0]       hit_waits;
    logic             hit_ro;
    logic [DATA_W-1:0] q_sel;

    region_decode #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .IDX_W  (IDX_W),
        .BASE   (BASE),
        .MASK   (MASK)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // Constant-index loops keep every parameter slice in range for any NREG.
    always_comb begin
        hit_waits = 2'd0;
        hit_ro    = 1'b0;
        q_sel     = OPEN_BUS;
        for (int i = 0; i < NREG; i++) begin
            if (hit_idx == IDX_W'(i)) begin
                hit_waits = WAITS[2*i +: 2];
                hit_ro    = RO[i];
            end
            if (lat_idx == IDX_W'(i)) begin
                q_sel = mem_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 2'd0;
            lat_idx   <= '0;
            lat_hit   <= 1'b0;
            lat_we    <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= OPEN_BUS;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sel   <= '0;
            mem_we    <= '0;
            err_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        state     <= ST_ACCESS;
                        lat_idx   <= hit_idx;
                        lat_hit   <= hit;
                        lat_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        wait_cnt  <= hit ? hit_waits : 2'd0;
                        mem_sel   <= hit ? (NREG'(1) << hit_idx) : '0;
                        mem_we    <= (hit && cpu_we && !hit_ro) ? (NREG'(1) << hit_idx) : '0;
                        if ((!hit || (cpu_we && hit_ro)) && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                ST_ACCESS: begin
                    mem_we <= '0;
                    if (wait_cnt == 2'd0) begin
                        state     <= ST_DONE;
                        mem_sel   <= '0;
                        cpu_ready <= 1'b1;
                        if (!lat_we)
                            cpu_rdata <= lat_hit ? q_sel : OPEN_BUS;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_DONE: begin
                    cpu_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b0;
                    mem_sel   <= '0;
                    mem_we    <= '0;
                end
            endcase
        end
    end

endmodule
